vmicro16_alu_arb: RTL
=====================

# vmicro16_alu_arb

Round-robin arbiter and sequencer that shares one `vmicro16_alu` and one `branch` condition evaluator among `CORES` requesters (per-core execute stages or coprocessor ports). Each requester presents an ALU op, two operands and a branch condition; the block grants one requester at a time. It captures the operands and runs the shared ALU. It then returns the registered result plus the branch-enable decision to the owner only. The block sits between the core execute stages and the single shared ALU instance.

## Interface
- `CORES`, 4, number of requesters, 2..8
- `DATA_W`, 16, operand/result width
- `OP_W`, 5, ALU opcode width
- `COND_W`, 8, branch condition width (`VMICRO16_OP_BR_*` encodings)
- `clk` in 1, single clock, rising edge
- `reset` in 1, asynchronous, active-low (asserted when 0)
- `req` in `CORES`, level request per requester; operands must be stable while high
- `op` in `CORES*OP_W`, packed opcode, requester i at `[i*OP_W +: OP_W]`
- `a` in `CORES*DATA_W`, packed operand A
- `b` in `CORES*DATA_W`, packed operand B
- `cond` in `CORES*COND_W`, packed branch condition
- `gnt` out `CORES`, one-hot one-cycle pulse: operands of that requester captured
- `rvalid` out `CORES`, one-hot one-cycle pulse: `rdata`/`ren` valid for that requester
- `rdata` out `DATA_W`, registered ALU result, broadcast
- `ren` out 1, registered branch enable computed from `rdata[3:0]` and the owner's `cond`
- `busy` out 1, high in EXEC and RESP

## Operation
- FSM states are IDLE, EXEC and RESP.
- **Reset:** state=IDLE, pointer=0, owner=0, operand regs=0. Outputs: `gnt`=0, `rvalid`=0, `rdata`=0, `ren`=0, `busy`=0.
- **IDLE:**
  - If any `req` bit is set, pick the winner.
  - The winner is the first set bit searching upward from pointer, wrapping modulo `CORES`.
  - Latch the winner's op/a/b/cond and the owner index.
  - Pulse `gnt[owner]` in the next cycle and go to EXEC.
  - If no `req` bit is set, stay in IDLE with all outputs at their idle values.
- **EXEC:**
  - The ALU and `branch` run combinationally on the latched regs.
  - Register the ALU `c` into `rdata`, register `en` into `ren`, and go to RESP.
- **RESP:**
  - `rvalid[owner]`=1 for this one cycle.
  - Pointer becomes (owner+1) mod `CORES`.
  - Go to IDLE.
- **Sampling rule:** `req` is sampled only in IDLE.
  - A requester drops `req` on seeing `gnt` unless it has another op.
  - A `req` still high in the first IDLE cycle after RESP counts as a new request.
- **Data hold:** `rdata`/`ren` hold their last value until the next EXEC, so no pulse-only data is lost.
- **Fairness:** with all requesters continuously active, grant order is 0,1,2,…,`CORES`-1,0,…
- **Starvation bound:** no requester waits more than `CORES`-1 operations.
- **Reset mid-operation:** immediately return to IDLE with reset values. Any pending result is discarded and no `rvalid` is issued for it.
- **Width rule:** operands and result are `DATA_W`, with no sign extension. For a compare opcode, flags are `rdata[3:0]` = N,Z,C,V.

## Timing
- IDLE sees `req` in cycle t. `gnt` is high in cycle t+1 (EXEC), and `rvalid`, `rdata` and `ren` are valid in cycle t+2 (RESP).
- Latency from request to result is 2 cycles. Issue rate is at most one op per 3 cycles.
- `gnt` and `rvalid` are registered, with no combinational path from `req`.
- The ALU/branch path must close timing within one cycle from the operand regs.

## Structure
- The shared package/include (`vmicro16_isa.v`) holds the `VMICRO16_OP_BR_*` and ALU opcode constants plus the local FSM state encodings `ARB_IDLE`, `ARB_EXEC` and `ARB_RESP`.
- Reuse the existing `vmicro16_alu` and `branch` as instances; this block does not duplicate them.
- One new sub-module, `vmicro16_rr_pick`:
  - Combinational round-robin picker with inputs `req`[`CORES`] and pointer.
  - Outputs `valid` and the winner index.

## Test plan
- **Reset/idle:** hold `reset`=0, then release with all `req`=0 for 5 cycles → `gnt`=0, `rvalid`=0, `rdata`=0, `ren`=0 and `busy`=0 throughout.
- **Single op:** req[1]=1, op=5'h19, a=0x000A, b=0x000B, cond=`BR_L` → `gnt`=4'b0010 one cycle later, then `rvalid`=4'b0010 with `rdata[3:0]`=4'b1000 and `ren`=1.
- **Equal operands:** req[2], op=5'h19, a=b=0x000A, cond=`BR_E` → `rdata[3:0]`=4'b0100 and `ren`=1. Repeat with cond=`BR_G` → `ren`=0.
- **Contention:** all four `req` high continuously from reset → grants in order 0,1,2,3,0, spaced exactly 3 cycles apart, with `rvalid` one-hot matching each grant.
- **Wrap and skip:** pointer at 3 with only req[0] and req[2] high → grants go 0 then 2, and requesters 1 and 3 are never granted.
- **Reset mid-op:**
  - Assert `reset`=0 during EXEC → `busy`=0 and no `rvalid` for the aborted op.
  - After release, req[3] alone → granted first (pointer=0 search reaches 3).

Source files
------------

// File: rtl/vmicro16_alu_arb_pkg.sv
// Shared vmicro16 ISA constants (ALU opcodes, branch conditions) and the
// arbiter FSM state encoding.
package vmicro16_alu_arb_pkg;

    localparam int unsigned ALU_OP_W  = 5;
    localparam int unsigned BR_COND_W = 8;

    localparam logic [ALU_OP_W-1:0] VMICRO16_ALU_ADD = 5'h0A;
    localparam logic [ALU_OP_W-1:0] VMICRO16_ALU_SUB = 5'h0B;
    localparam logic [ALU_OP_W-1:0] VMICRO16_ALU_AND = 5'h0C;
    localparam logic [ALU_OP_W-1:0] VMICRO16_ALU_OR  = 5'h0D;
    localparam logic [ALU_OP_W-1:0] VMICRO16_ALU_XOR = 5'h0E;
    localparam logic [ALU_OP_W-1:0] VMICRO16_ALU_NOT = 5'h0F;
    localparam logic [ALU_OP_W-1:0] VMICRO16_ALU_SHL = 5'h10;
    localparam logic [ALU_OP_W-1:0] VMICRO16_ALU_SHR = 5'h11;
    localparam logic [ALU_OP_W-1:0] VMICRO16_ALU_MOV = 5'h12;
    localparam logic [ALU_OP_W-1:0] VMICRO16_ALU_CMP = 5'h19;

    // Conditions test the flag nibble {N,Z,C,V}; C means unsigned a > b.
    localparam logic [BR_COND_W-1:0] VMICRO16_OP_BR_U  = 8'h00;
    localparam logic [BR_COND_W-1:0] VMICRO16_OP_BR_E  = 8'h01;
    localparam logic [BR_COND_W-1:0] VMICRO16_OP_BR_NE = 8'h02;
    localparam logic [BR_COND_W-1:0] VMICRO16_OP_BR_G  = 8'h03;
    localparam logic [BR_COND_W-1:0] VMICRO16_OP_BR_GE = 8'h04;
    localparam logic [BR_COND_W-1:0] VMICRO16_OP_BR_L  = 8'h05;
    localparam logic [BR_COND_W-1:0] VMICRO16_OP_BR_LE = 8'h06;
    localparam logic [BR_COND_W-1:0] VMICRO16_OP_BR_A  = 8'h07;
    localparam logic [BR_COND_W-1:0] VMICRO16_OP_BR_BE = 8'h08;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/branch.sv
// Branch condition evaluator over the {N,Z,C,V} flag nibble.
module branch
    import vmicro16_alu_arb_pkg::*;
#(
    parameter int unsigned COND_W = 8
) (
    input  logic [3:0]        flags,
    input  logic [COND_W-1:0] cond,
    output logic              en
);

    logic fn, fz, fc, fv;

    always_comb begin
        {fn, fz, fc, fv} = flags;
        en = 1'b0;
        case (cond)
            COND_W'(VMICRO16_OP_BR_U):  en = 1'b1;
            COND_W'(VMICRO16_OP_BR_E):  en = fz;
            COND_W'(VMICRO16_OP_BR_NE): en = !fz;
            COND_W'(VMICRO16_OP_BR_G):  en = !fz && (fn == fv);
            COND_W'(VMICRO16_OP_BR_GE): en = (fn == fv);
            COND_W'(VMICRO16_OP_BR_L):  en = (fn != fv);
            COND_W'(VMICRO16_OP_BR_LE): en = fz || (fn != fv);
            COND_W'(VMICRO16_OP_BR_A):  en = fc;
            COND_W'(VMICRO16_OP_BR_BE): en = !fc;
            default:                    en = 1'b0;
        endcase
    end

endmodule

// File: rtl/vmicro16_alu.sv
// Shared vmicro16 ALU: purely combinational, compare packs N,Z,C,V into c[3:0].
module vmicro16_alu
    import vmicro16_alu_arb_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OP_W   = 5
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c
);

    logic [DATA_W-1:0] diff;
    logic              fn, fz, fc, fv;

    always_comb begin
        diff = a - b;
        fn   = diff[DATA_W-1];
        fz   = (diff == '0);
        fc   = (a > b);
        fv   = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
        c    = '0;
        case (op)
            OP_W'(VMICRO16_ALU_ADD): c = a + b;
            OP_W'(VMICRO16_ALU_SUB): c = diff;
            OP_W'(VMICRO16_ALU_AND): c = a & b;
            OP_W'(VMICRO16_ALU_OR):  c = a | b;
            OP_W'(VMICRO16_ALU_XOR): c = a ^ b;
            OP_W'(VMICRO16_ALU_NOT): c = ~a;
            OP_W'(VMICRO16_ALU_SHL): c = a << b[3:0];
            OP_W'(VMICRO16_ALU_SHR): c = a >> b[3:0];
            OP_W'(VMICRO16_ALU_MOV): c = b;
            OP_W'(VMICRO16_ALU_CMP): c = DATA_W'({fn, fz, fc, fv});
            default:                 c = '0;
        endcase
    end

endmodule

// File: rtl/vmicro16_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module vmicro16_rr_pick #(
    parameter int unsigned CORES = 4
) (
    input  logic [CORES-1:0]         req,
    input  logic [$clog2(CORES)-1:0] ptr,
    output logic                     valid_c,
    output logic [$clog2(CORES)-1:0] idx_c
);

    localparam int unsigned PTR_W = $clog2(CORES);

    logic [PTR_W-1:0] j;

    always_comb begin
        valid_c = 1'b0;
        idx_c   = '0;
        j       = '0;
        for (int unsigned i = 0; i < CORES; i++) begin
            j = PTR_W'((32'(ptr) + i) % CORES);
            if (!valid_c && req[j]) begin
                valid_c = 1'b1;
                idx_c   = j;
            end
        end
    end

endmodule

// File: rtl/vmicro16_alu_arb.sv
// Round-robin arbiter sharing one vmicro16_alu and one branch evaluator
// among CORES requesters; IDLE -> EXEC -> RESP per operation.
module vmicro16_alu_arb
    import vmicro16_alu_arb_pkg::*;
#(
    parameter int unsigned CORES  = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OP_W   = 5,
    parameter int unsigned COND_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CORES-1:0]           req,
    input  logic [CORES*OP_W-1:0]      op,
    input  logic [CORES*DATA_W-1:0]    a,
    input  logic [CORES*DATA_W-1:0]    b,
    input  logic [CORES*COND_W-1:0]    cond,
    output logic [CORES-1:0]           gnt,
    output logic [CORES-1:0]           rvalid,
    output logic [DATA_W-1:0]          rdata,
    output logic                       ren,
    output logic                       busy
);

    localparam int unsigned PTR_W = $clog2(CORES);

    arb_state_e          state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [COND_W-1:0]   cond_q, cond_d;
    logic [CORES-1:0]    gnt_q, gnt_d;
    logic [CORES-1:0]    rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ren_q, ren_d;
    logic                busy_q, busy_d;

    logic                pick_valid;
    logic [PTR_W-1:0]    pick_idx;
    logic [DATA_W-1:0]   alu_c;
    logic                br_en;

    vmicro16_rr_pick #(.CORES(CORES)) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .valid_c (pick_valid),
        .idx_c   (pick_idx)
    );

    vmicro16_alu #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .c  (alu_c)
    );

    branch #(.COND_W(COND_W)) u_branch (
        .flags (alu_c[3:0]),
        .cond  (cond_q),
        .en    (br_en)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ARB_IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cond_q   <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            ren_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cond_q   <= cond_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            ren_q    <= ren_d;
            busy_q   <= busy_d;
        end
    end

    // Pulses default low; rdata/ren hold until the next EXEC.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cond_d   = cond_q;
        gnt_d    = '0;
        rvalid_d = '0;
        rdata_d  = rdata_q;
        ren_d    = ren_q;
        busy_d   = busy_q;
        case (state_q)
            ARB_IDLE: begin
                busy_d = 1'b0;
                if (pick_valid) begin
                    owner_d = pick_idx;
                    op_d    = op[32'(pick_idx) * OP_W +: OP_W];
                    a_d     = a[32'(pick_idx) * DATA_W +: DATA_W];
                    b_d     = b[32'(pick_idx) * DATA_W +: DATA_W];
                    cond_d  = cond[32'(pick_idx) * COND_W +: COND_W];
                    gnt_d   = CORES'(1) << pick_idx;
                    busy_d  = 1'b1;
                    state_d = ARB_EXEC;
                end
            end
            ARB_EXEC: begin
                rdata_d  = alu_c;
                ren_d    = br_en;
                rvalid_d = CORES'(1) << owner_q;
                busy_d   = 1'b1;
                state_d  = ARB_RESP;
            end
            ARB_RESP: begin
                ptr_d   = (owner_q == PTR_W'(CORES - 1)) ? '0 : owner_q + PTR_W'(1);
                busy_d  = 1'b0;
                state_d = ARB_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign gnt    = gnt_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign ren    = ren_q;
    assign busy   = busy_q;

endmodule
